// File: rtl/lms_seq.sv
// lms_seq: sample sequencer for the 16-tap LMS noise canceller.
// Fires the filter per sample, forms e = d - y, supervises completion.
module lms_seq #(
   parameter int X_W      = 16,
   parameter int Y_W      = 16,
   parameter int E_W      = 16,
   parameter int MU_SHIFT = 4,
   parameter int TMO_CYC  = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic signed [X_W-1:0] x_in,
   input  logic signed [Y_W-1:0] d_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  adapt_en,
   output logic                  lms_en,
   output logic signed [X_W-1:0] lms_xin,
   output logic signed [E_W-1:0] lms_err,
   output logic                  lms_rst_n,
   input  logic                  lms_update,
   input  logic signed [Y_W-1:0] lms_yout,
   output logic signed [Y_W-1:0] e_out,
   output logic signed [Y_W-1:0] y_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [15:0]           sample_cnt,
   output logic                  timeout
);

   localparam int CW = $clog2(TMO_CYC);
   localparam logic [CW-1:0] LAST = CW'(TMO_CYC - 1);
   // wide enough to hold both the shifted error and the E_W limits
   localparam int SW = ((Y_W + 1) > E_W) ? Y_W + 2 : E_W + 1;

   localparam logic signed [Y_W:0] Y_MAX = {2'b00, {(Y_W-1){1'b1}}};
   localparam logic signed [Y_W:0] Y_MIN = {2'b11, {(Y_W-1){1'b0}}};
   localparam logic signed [SW-1:0] E_MAX =
      {{(SW-E_W+1){1'b0}}, {(E_W-1){1'b1}}};
   localparam logic signed [SW-1:0] E_MIN =
      {{(SW-E_W+1){1'b1}}, {(E_W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_OUT
   } state_t;

   state_t state, state_nx;

   logic signed [Y_W-1:0] d_reg;
   logic [CW-1:0]         wcnt;
   logic                  rst_n_q;
   logic                  accept, done, tmo, fin;

   logic signed [Y_W:0]   e_full;
   logic signed [Y_W:0]   e_sh;
   logic signed [SW-1:0]  sh_ext;
   logic signed [Y_W-1:0] e_sat;
   logic signed [E_W-1:0] err_sat;

   // error at Y_W+1 bits so d - y can never wrap
   assign e_full = {d_reg[Y_W-1], d_reg} - {lms_yout[Y_W-1], lms_yout};
   assign e_sh   = e_full >>> MU_SHIFT;
   assign sh_ext = {{(SW-Y_W-1){e_sh[Y_W]}}, e_sh};

   // clamp the cleaned sample and the scaled error to their widths
   always_comb begin
      e_sat   = e_full[Y_W-1:0];
      err_sat = sh_ext[E_W-1:0];
      if (e_full > Y_MAX) e_sat = Y_MAX[Y_W-1:0];
      else if (e_full < Y_MIN) e_sat = Y_MIN[Y_W-1:0];
      if (sh_ext > E_MAX) err_sat = E_MAX[E_W-1:0];
      else if (sh_ext < E_MIN) err_sat = E_MIN[E_W-1:0];
   end

   // next-state and per-cycle event decode
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      done     = 1'b0;
      tmo      = 1'b0;
      fin      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (in_valid) begin
               accept   = 1'b1;
               state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            // a completion on the last counted cycle beats the timeout
            if (lms_update) begin
               done     = 1'b1;
               state_nx = S_OUT;
            end else if (wcnt == LAST) begin
               tmo      = 1'b1;
               state_nx = S_IDLE;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               fin      = 1'b1;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign in_ready  = (state == S_IDLE) & ~rst;
   assign out_valid = (state == S_OUT);
   assign lms_rst_n = rst_n_q & ~rst;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // datapath, filter control and status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         lms_en     <= 1'b0;
         lms_xin    <= '0;
         lms_err    <= '0;
         d_reg      <= '0;
         wcnt       <= '0;
         e_out      <= '0;
         y_out      <= '0;
         sample_cnt <= '0;
         timeout    <= 1'b0;
         rst_n_q    <= 1'b0;
      end else begin
         lms_en  <= accept;
         rst_n_q <= ~tmo;
         if (accept) begin
            lms_xin <= x_in;
            d_reg   <= d_in;
            wcnt    <= '0;
         end else if (state == S_WAIT) begin
            wcnt <= wcnt + 1'b1;
         end
         if (done) begin
            y_out   <= lms_yout;
            e_out   <= e_sat;
            lms_err <= adapt_en ? err_sat : '0;
         end
         if (tmo) timeout <= 1'b1;
         if (fin) sample_cnt <= sample_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_lms_seq.sv
// tb_lms_seq: directed checks of the LMS sample sequencer.
// Filter is modelled by hand-driven lms_update/lms_yout.
module tb_lms_seq;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic signed [15:0] x_in = '0;
   logic signed [15:0] d_in = '0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic               adapt_en = 1'b1;
   logic               lms_en;
   logic signed [15:0] lms_xin;
   logic signed [15:0] lms_err;
   logic               lms_rst_n;
   logic               lms_update = 1'b0;
   logic signed [15:0] lms_yout = '0;
   logic signed [15:0] e_out;
   logic signed [15:0] y_out;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [15:0]        sample_cnt;
   logic               timeout;

   int n_run  = 0;
   int n_fail = 0;
   int en_cnt = 0;

   lms_seq #(
      .X_W(16), .Y_W(16), .E_W(16), .MU_SHIFT(4), .TMO_CYC(8)
   ) dut (
      .clk(clk), .rst(rst),
      .x_in(x_in), .d_in(d_in),
      .in_valid(in_valid), .in_ready(in_ready),
      .adapt_en(adapt_en),
      .lms_en(lms_en), .lms_xin(lms_xin),
      .lms_err(lms_err), .lms_rst_n(lms_rst_n),
      .lms_update(lms_update), .lms_yout(lms_yout),
      .e_out(e_out), .y_out(y_out),
      .out_valid(out_valid), .out_ready(out_ready),
      .sample_cnt(sample_cnt), .timeout(timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (lms_en) en_cnt++;

   task automatic chk(input string tag, input int got, input int exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present one pair, land in the lms_en cycle
   task automatic start_sample(input int x, input int d);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      chk("in_ready_wait", int'(in_ready), 1);
      x_in     = 16'(x);
      d_in     = 16'(d);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("lms_en_pulse", int'(lms_en), 1);
      chk("lms_xin", int'(lms_xin), x);
   endtask

   // filter answers lat cycles after lms_en; lands in first OUT cycle
   task automatic finish_filter(input int y, input int lat, input int err);
      for (int i = 1; i < lat; i++) begin
         tick();
         chk("lms_en_once", int'(lms_en), 0);
         chk("no_valid_wait", int'(out_valid), 0);
         chk("err_stable", int'(lms_err), err);
         chk("xin_held", int'(lms_xin), int'(x_in));
      end
      tick();
      lms_update = 1'b1;
      lms_yout   = 16'(y);
      tick();
      lms_update = 1'b0;
      chk("out_valid", int'(out_valid), 1);
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("valid_drop", int'(out_valid), 0);
      chk("in_ready_back", int'(in_ready), 1);
   endtask

   initial begin
      // reset state
      tick(); tick();
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_lms_en", int'(lms_en), 0);
      chk("rst_lms_err", int'(lms_err), 0);
      chk("rst_lms_rst_n", int'(lms_rst_n), 0);
      chk("rst_cnt", int'(sample_cnt), 0);
      chk("rst_timeout", int'(timeout), 0);
      chk("rst_e_out", int'(e_out), 0);
      rst = 1'b0;
      tick();
      chk("idle_in_ready", int'(in_ready), 1);
      chk("lms_rst_n_up", int'(lms_rst_n), 1);

      // basic flow
      start_sample(100, 1000);
      finish_filter(200, 3, 0);
      chk("basic_e", int'(e_out), 800);
      chk("basic_y", int'(y_out), 200);
      chk("basic_err", int'(lms_err), 50);
      handshake();
      chk("basic_cnt", int'(sample_cnt), 1);
      chk("basic_en_cnt", en_cnt, 1);
      chk("basic_err_hold", int'(lms_err), 50);

      // positive saturation
      start_sample(1, 32767);
      finish_filter(-32768, 3, 50);
      chk("satp_e", int'(e_out), 32767);
      chk("satp_err", int'(lms_err), 4095);
      handshake();

      // negative saturation
      start_sample(2, -32768);
      finish_filter(32767, 2, 4095);
      chk("satn_e", int'(e_out), -32768);
      chk("satn_err", int'(lms_err), -4096);
      handshake();

      // freeze
      adapt_en = 1'b0;
      start_sample(3, 500);
      finish_filter(100, 3, -4096);
      chk("frz_e", int'(e_out), 400);
      chk("frz_err", int'(lms_err), 0);
      handshake();
      adapt_en = 1'b1;

      // backpressure with a stray completion pulse in OUT
      start_sample(4, 300);
      finish_filter(-20, 3, 0);
      for (int i = 0; i < 10; i++) begin
         lms_update = (i == 3);
         lms_yout   = 16'sd77;
         in_valid   = 1'b1;
         tick();
         chk("bp_valid", int'(out_valid), 1);
         chk("bp_e", int'(e_out), 320);
         chk("bp_y", int'(y_out), -20);
         chk("bp_in_ready", int'(in_ready), 0);
      end
      lms_update = 1'b0;
      in_valid   = 1'b0;
      chk("bp_err", int'(lms_err), 20);
      handshake();
      chk("bp_cnt", int'(sample_cnt), 5);

      // timeout: no completion
      start_sample(5, 900);
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("tmo_early", int'(timeout), 0);
         chk("tmo_rst_n_hi", int'(lms_rst_n), 1);
         chk("tmo_no_valid", int'(out_valid), 0);
      end
      tick();
      chk("tmo_flag", int'(timeout), 1);
      chk("tmo_rst_n_lo", int'(lms_rst_n), 0);
      chk("tmo_in_ready", int'(in_ready), 1);
      tick();
      chk("tmo_rst_n_one", int'(lms_rst_n), 1);
      chk("tmo_no_valid2", int'(out_valid), 0);
      chk("tmo_cnt", int'(sample_cnt), 5);
      chk("tmo_err", int'(lms_err), 20);

      // completion on final counted cycle beats timeout
      start_sample(6, 50);
      finish_filter(10, 7, 20);
      chk("late_e", int'(e_out), 40);
      chk("late_err", int'(lms_err), 2);
      chk("late_tmo", int'(timeout), 1);
      chk("late_rst_n", int'(lms_rst_n), 1);
      handshake();
      chk("late_cnt", int'(sample_cnt), 6);

      // reset during WAIT
      start_sample(7, 70);
      tick();
      rst = 1'b1;
      tick();
      chk("rw_lms_rst_n", int'(lms_rst_n), 0);
      chk("rw_err", int'(lms_err), 0);
      chk("rw_cnt", int'(sample_cnt), 0);
      chk("rw_tmo", int'(timeout), 0);
      chk("rw_xin", int'(lms_xin), 0);
      rst = 1'b0;
      tick();
      lms_update = 1'b1;
      lms_yout   = 16'sd5;
      tick();
      lms_update = 1'b0;
      chk("rw_ignore_upd", int'(out_valid), 0);
      chk("rw_ignore_y", int'(y_out), 0);
      chk("rw_idle", int'(in_ready), 1);

      // reset during OUT
      start_sample(8, 10);
      finish_filter(0, 3, 0);
      chk("ro_e", int'(e_out), 10);
      rst = 1'b1;
      tick();
      chk("ro_valid", int'(out_valid), 0);
      chk("ro_e0", int'(e_out), 0);
      chk("ro_y0", int'(y_out), 0);
      chk("ro_err0", int'(lms_err), 0);
      rst = 1'b0;
      tick();

      // counter wrap
      dut.sample_cnt = 16'hFFFF;
      start_sample(9, 16);
      finish_filter(0, 3, 0);
      chk("wrap_err", int'(lms_err), 1);
      chk("wrap_pre", int'(sample_cnt), 65535);
      handshake();
      chk("wrap_cnt", int'(sample_cnt), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
